// File: rtl/data_memory_controller_pkg.sv
// Shared types and width helpers for the data-memory controller and its load aligner.
package data_memory_controller_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        Idle = 2'd0,
        Wait = 2'd1,
        Done = 2'd2
    } mem_ctrl_state_t;

    function automatic int unsigned lane_count(input int unsigned data_size);
        return data_size / BYTE_W;
    endfunction

    function automatic int unsigned offset_width(input int unsigned data_size);
        return $clog2(data_size / BYTE_W);
    endfunction

endpackage

// File: rtl/data_memory_controller_load_aligner.sv
// Shifts bus read data down to the addressed byte lane, masks it to the access
// size and sign- or zero-extends from the top enabled byte.
module load_aligner
    import data_memory_controller_pkg::*;
#(
    parameter int unsigned DATA_SIZE = 32
) (
    input  logic [DATA_SIZE-1:0]                    data_i,
    input  logic [offset_width(DATA_SIZE)-1:0]      off_i,
    input  logic [lane_count(DATA_SIZE)-1:0]        byte_en_i,
    input  logic                                    sign_i,
    output logic [DATA_SIZE-1:0]                    data_o
);

    localparam int unsigned LANES = lane_count(DATA_SIZE);

    logic [DATA_SIZE-1:0] shifted;
    logic [LANES-1:0]     top_lane;
    logic [LANES-1:0]     lane_msb;
    logic                 ext_bit;

    assign shifted = data_i >> {off_i, 3'b000};

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            // Size masks are contiguous from lane 0, so the top lane is the last set bit.
            if (gi == LANES - 1) begin : g_last
                assign top_lane[gi] = byte_en_i[gi];
            end else begin : g_inner
                assign top_lane[gi] = byte_en_i[gi] & ~byte_en_i[gi+1];
            end
            assign lane_msb[gi] = shifted[BYTE_W*gi + BYTE_W-1];
            assign data_o[BYTE_W*gi +: BYTE_W] = byte_en_i[gi] ? shifted[BYTE_W*gi +: BYTE_W]
                                                               : {BYTE_W{ext_bit}};
        end
    endgenerate

    assign ext_bit = sign_i & (|(top_lane & lane_msb));

endmodule

// File: rtl/data_memory_controller.sv
// Responder for the core's level-held load/store request, bridged onto a Wishbone-classic bus.
// Optional bus watchdog: define MEM_CTRL_TIMEOUT_EN to enable the TIMEOUT_CYCLES limit in Wait.
module data_memory_controller
    import data_memory_controller_pkg::*;
#(
    parameter int unsigned DATA_SIZE      = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               rd_en,
    input  logic                               wr_en,
    input  logic [DATA_SIZE-1:0]               addr,
    input  logic [DATA_SIZE-1:0]               wr_data,
    input  logic [lane_count(DATA_SIZE)-1:0]   byte_en,
    input  logic                               mem_signed,
    output logic [DATA_SIZE-1:0]               rd_data,
    output logic                               mem_busy,
    output logic                               misaligned,
    output logic                               access_fault,
    output logic                               wb_cyc,
    output logic                               wb_stb,
    output logic                               wb_we,
    output logic [DATA_SIZE-1:0]               wb_adr,
    output logic [lane_count(DATA_SIZE)-1:0]   wb_sel,
    output logic [DATA_SIZE-1:0]               wb_dat_o,
    input  logic [DATA_SIZE-1:0]               wb_dat_i,
    input  logic                               wb_ack
);

    localparam int unsigned LANES = lane_count(DATA_SIZE);
    localparam int unsigned OFF_W = offset_width(DATA_SIZE);

    mem_ctrl_state_t      state_q, state_d;
    logic [DATA_SIZE-1:0] rd_data_q, rd_data_d;
    logic                 misaligned_q, misaligned_d;

    logic                 req;
    logic [OFF_W-1:0]     off;
    logic [OFF_W-1:0]     size_mask;
    logic                 addr_misaligned;
    logic                 bus_active;
    logic                 busy_c;
    logic                 capture_load;
    logic                 capture_zero;
    logic [DATA_SIZE-1:0] load_ext;

    assign req = rd_en | wr_en;
    assign off = addr[OFF_W-1:0];

    // Byte enables are 1/3/F/FF, so bit j of (size-1) is simply byte_en[2**j].
    genvar gi;
    generate
        for (gi = 0; gi < OFF_W; gi++) begin : g_size_mask
            assign size_mask[gi] = byte_en[1 << gi];
        end
    endgenerate

    assign addr_misaligned = |(off & size_mask);

    load_aligner #(
        .DATA_SIZE (DATA_SIZE)
    ) u_load_aligner (
        .data_i    (wb_dat_i),
        .off_i     (off),
        .byte_en_i (byte_en),
        .sign_i    (mem_signed),
        .data_o    (load_ext)
    );

`ifdef MEM_CTRL_TIMEOUT_EN
    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMR_W-1:0] timer_q, timer_d;
    logic             fault_q, fault_d;

    assign timer_d      = (state_q == Wait) ? timer_q + 1'b1 : '0;
    assign access_fault = fault_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            timer_q <= '0;
            fault_q <= 1'b0;
        end else begin
            timer_q <= timer_d;
            fault_q <= fault_d;
        end
    end
`else
    assign access_fault = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        misaligned_d = 1'b0;
        bus_active   = 1'b0;
        busy_c       = 1'b0;
        capture_load = 1'b0;
        capture_zero = 1'b0;
`ifdef MEM_CTRL_TIMEOUT_EN
        fault_d      = 1'b0;
`endif
        case (state_q)
            Idle: begin
                if (req) begin
                    busy_c = 1'b1;
                    if (addr_misaligned) begin
                        state_d      = Done;
                        misaligned_d = 1'b1;
                        capture_zero = 1'b1;
                    end else begin
                        bus_active = 1'b1;
                        if (wb_ack) begin
                            state_d      = Done;
                            capture_load = ~wr_en;
                        end else begin
                            state_d = Wait;
                        end
                    end
                end
            end
            Wait: begin
                busy_c     = 1'b1;
                bus_active = 1'b1;
                if (wb_ack) begin
                    state_d      = Done;
                    capture_load = ~wr_en;
                end
`ifdef MEM_CTRL_TIMEOUT_EN
                else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d      = Done;
                    fault_d      = 1'b1;
                    capture_zero = 1'b1;
                end
`endif
            end
            Done:    state_d = Idle;
            default: state_d = Idle;
        endcase
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (capture_zero) begin
            rd_data_d = '0;
        end else if (capture_load) begin
            rd_data_d = load_ext;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= Idle;
            rd_data_q    <= '0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_data_q    <= rd_data_d;
            misaligned_q <= misaligned_d;
        end
    end

    // Reset gates the combinational outputs so a held request cannot re-raise the bus during reset.
    assign wb_cyc     = bus_active & reset;
    assign wb_stb     = bus_active & reset;
    assign wb_we      = bus_active & reset & wr_en;
    assign wb_sel     = (bus_active & reset) ? (byte_en << off) : '0;
    assign wb_adr     = {addr[DATA_SIZE-1:OFF_W], {OFF_W{1'b0}}};
    assign wb_dat_o   = wr_data << {off, 3'b000};
    assign mem_busy   = busy_c & reset;
    assign misaligned = misaligned_q;
    assign rd_data    = rd_data_q;

endmodule
